word_tx_serializer: RTL and testbench
=====================================

// Module: word_tx_serializer
// PURPOSE
//  Transmit-side counterpart of the 32-bit byte-assembly input path.
//  - On start, captures a 32-bit result word.
//  - Sends it as 4 bytes, LSB first, through a byte-wide UART transmitter.
//  - Paces each byte with a tx_start / tx_busy handshake; pulses done when the frame completes.
//  - Sits between the result datapath and the UART tx core.
// PARAMETERS
//  NUM_BYTES  4  bytes per frame (excluding optional checksum); fixed 4 in this design
//  BYTE_W     8  bits per UART character
// PORTS
//  clk          in   1   clock
//  reset        in   1   reset, synchronous, active-high
//  start        in   1   1-cycle request to send result_data; ignored unless idle
//  result_data  in   32  word to transmit, sampled on the accepting edge only
//  tx_busy      in   1   UART tx busy; rises after it accepts tx_start, falls when the char is done
//  tx_start     out  1   registered 1-cycle pulse; tx_data is valid with it
//  tx_data      out  8   registered byte; held stable until the next tx_start
//  busy         out  1   high from the accepting edge until the done pulse, inclusive
//  done         out  1   registered 1-cycle pulse after the last byte's tx_busy falls
// BEHAVIOUR
//  Reset values: tx_start=0, tx_data=0, busy=0, done=0, state=IDLE, byte_idx=0, shift reg=0.
//  FSM states: IDLE, SEND, WAIT_ACK, WAIT_DONE, DONE.
//  - IDLE:
//    - start=1: latch result_data, byte_idx<=0, busy<=1, go to SEND.
//    - else: stay.
//  - SEND:
//    - tx_busy=0: tx_start<=1, tx_data<=byte[byte_idx], go to WAIT_ACK.
//    - tx_busy=1: wait, no pulse.
//  - WAIT_ACK: tx_start<=0. tx_busy=1 -> WAIT_DONE; otherwise wait indefinitely (no timeout).
//  - WAIT_DONE: on tx_busy=0:
//    - byte_idx==LAST: go to DONE.
//    - else: byte_idx++, go to SEND.
//  - DONE: done<=1 for one cycle, busy<=0, go to IDLE.
//  Byte order: byte[0]=result[7:0], byte[1]=[15:8], byte[2]=[23:16], byte[3]=[31:24].
//  Latency: start accepted at edge k -> tx_start high after edge k+1 if tx_busy=0.
//  Exactly one tx_start per byte; never two tx_start pulses without a tx_busy high->low cycle between.
//  start while busy=1: ignored, captured word unchanged.
//  start in the DONE cycle: ignored; earliest new accept is the next cycle in IDLE.
//  Simultaneous start and reset: reset wins.
//  Reset mid-frame: aborts at once, all outputs to reset values, no done pulse.
//  result_data changes after capture: no effect on the frame in progress.
// CONFIGURATION
//  Macro WORD_TX_CHECKSUM_EN:
//  - Defined: a 5th byte = byte0^byte1^byte2^byte3 is sent after byte[3] with the same handshake.
//    LAST = 4, frame is 5 chars.
//  - Undefined: LAST = 3, 4-char frame, no checksum logic present.
// STRUCTURE
//  Package word_tx_pkg:
//  - typedef enum logic [2:0] word_tx_state_t {IDLE, SEND, WAIT_ACK, WAIT_DONE, DONE}.
//  - localparams NUM_BYTES and BYTE_W.
//  - function xor_checksum(logic [31:0]) returns logic [7:0].
//  No sub-module: single FSM plus capture register and byte index counter.
// TESTING
//  - Basic frame: start with 0xDEADBEEF; tx model busy 10 cycles per char
//    -> tx_data EF,BE,AD,DE in order; 4 tx_start pulses; done 1 cycle after the 4th busy falls.
//  - Busy at start: tx_busy=1 when start=1 with 0x00000001
//    -> no tx_start until tx_busy=0; first byte 0x01.
//  - Ignore while busy: second start with 0x12345678 mid-frame
//    -> the frame still sends the first word; no extra bytes; busy stays 1.
//  - Reset mid-frame: reset after the 2nd tx_start
//    -> next cycle tx_start=0, busy=0, done never pulses; a new start sends a full frame from byte 0.
//  - Checksum (WORD_TX_CHECKSUM_EN): 0x01020304
//    -> bytes 04,03,02,01,04 (xor); done after the 5th char.
//  - Back-to-back: start asserted in the cycle after done with 0xA5A5A5A5
//    -> accepted; busy re-asserts; 4 bytes of A5.

Source files
------------

// File: rtl/word_tx_serializer_pkg.sv
// word_tx_pkg: shared types and helpers for the word transmit serializer.
package word_tx_pkg;
  localparam int NUM_BYTES = 4;
  localparam int BYTE_W = 8;
  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE, DONE} word_tx_state_t;
  function automatic logic [7:0] xor_checksum(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction
endpackage

// File: rtl/word_tx_serializer.sv
// word_tx_serializer: sends a captured 32-bit word LSB first as UART bytes; WORD_TX_CHECKSUM_EN appends an XOR byte.
module word_tx_serializer
  import word_tx_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_BYTES*BYTE_W-1:0] result_data,
  input  logic                        tx_busy,
  output logic                        tx_start,
  output logic [BYTE_W-1:0]           tx_data,
  output logic                        busy,
  output logic                        done
);
`ifdef WORD_TX_CHECKSUM_EN
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam logic [2:0] LAST = 3'd3;
`endif
  word_tx_state_t              state;
  logic [2:0]                  byte_idx;
  logic [NUM_BYTES*BYTE_W-1:0] word_reg;
  logic [BYTE_W-1:0]           cur_byte;
`ifdef WORD_TX_CHECKSUM_EN
  always_comb cur_byte = (byte_idx == 3'd4) ? xor_checksum(word_reg) : word_reg[{byte_idx[1:0], 3'b000} +: BYTE_W];
`else
  always_comb cur_byte = word_reg[{byte_idx[1:0], 3'b000} +: BYTE_W];
`endif
  // done is raised on the final tx_busy fall so busy still covers the pulse cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      byte_idx <= '0;
      word_reg <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: if (start) begin
          word_reg <= result_data;
          byte_idx <= '0;
          busy     <= 1'b1;
          state    <= SEND;
        end
        SEND: if (!tx_busy) begin
          tx_start <= 1'b1;
          tx_data  <= cur_byte;
          state    <= WAIT_ACK;
        end
        WAIT_ACK: if (tx_busy) state <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) begin
          if (byte_idx == LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            byte_idx <= byte_idx + 3'd1;
            state    <= SEND;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_word_tx_serializer.sv
// tb_word_tx_serializer: randomized frames against a UART responder and a byte-list reference model.
module tb_word_tx_serializer;
  logic        clk = 1'b0;
  logic        reset, start, tx_busy, tx_start, busy, done;
  logic [31:0] result_data;
  logic [7:0]  tx_data;
  int          n_chk = 0, n_pass = 0;
  logic [7:0]  got_q[$];
  int          cyc = 0, fall_cyc = -100, n_done = 0, cnt = 0, lat = 0, hold = 0, char_len = 0;
  bit          pend = 0;

  always #5 clk = ~clk;

  word_tx_serializer dut (
    .clk(clk), .reset(reset), .start(start), .result_data(result_data),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // UART responder: records each character, holds tx_busy for a random length
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
        cnt = 0;
        pend = 0;
        tx_busy = 1'b0;
      end else begin
        if (done) begin
          n_done++;
          check("done_latency", cyc - fall_cyc, 1);
        end
        if (tx_start) begin
          check("one_start_per_char", {31'b0, cnt == 0 && !pend && hold == 0}, 1);
          got_q.push_back(tx_data);
          pend = 1;
          lat = (char_len != 0) ? 0 : $urandom_range(0, 2);
        end
        if (hold > 0) begin
          hold--;
          tx_busy = (hold != 0);
        end else if (pend) begin
          if (lat == 0) begin
            pend = 0;
            tx_busy = 1'b1;
            cnt = (char_len != 0) ? char_len : $urandom_range(1, 12);
          end else lat--;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            tx_busy = 1'b0;
            fall_cyc = cyc;
          end
        end
      end
    end
  end

  task automatic run_frame(input logic [31:0] w, input int hold_cyc, input int poke_at, input bit done_poke);
    logic [7:0] exp_q[$];
    bit busy_ok = 1;
    for (int b = 0; b < 4; b++) exp_q.push_back(8'(w >> (8 * b)));
`ifdef WORD_TX_CHECKSUM_EN
    exp_q.push_back(exp_q[0] ^ exp_q[1] ^ exp_q[2] ^ exp_q[3]);
`endif
    got_q.delete();
    if (hold_cyc > 0) begin
      hold = hold_cyc;
      @(negedge clk);
    end
    start = 1'b1;
    result_data = w;
    @(negedge clk);
    start = 1'b0;
    result_data = $urandom;
    check("busy_on_accept", {31'b0, busy}, 1);
    if (hold_cyc == 0) begin
      @(negedge clk);
      check("first_tx_start_latency", {31'b0, tx_start}, 1);
    end
    for (int i = 0; i < 3000 && !done; i++) begin
      if (i == poke_at) begin
        start = 1'b1;
        result_data = 32'h12345678;
      end else start = 1'b0;
      if (!busy) busy_ok = 0;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_stays_high", {31'b0, busy_ok}, 1);
    check("done_seen", {31'b0, done}, 1);
    check("busy_with_done", {31'b0, busy}, 1);
    check("byte_count", got_q.size(), exp_q.size());
    for (int b = 0; b < exp_q.size() && b < got_q.size(); b++)
      check($sformatf("byte%0d", b), {24'b0, got_q[b]}, {24'b0, exp_q[b]});
    if (done_poke) begin
      start = 1'b1;
      result_data = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", {31'b0, done}, 0);
    check("busy_cleared", {31'b0, busy}, 0);
    if (done_poke) begin
      @(negedge clk);
      check("start_in_done_ignored", {31'b0, busy}, 0);
    end
  endtask

  task automatic reset_mid_frame();
    int nd;
    got_q.delete();
    start = 1'b1;
    result_data = 32'h89ABCDEF;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && got_q.size() < 2; i++) @(negedge clk);
    check("two_bytes_before_reset", got_q.size(), 2);
    nd = n_done;
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    check("rst_tx_start", {31'b0, tx_start}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_tx_data", {24'b0, tx_data}, 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("start_with_reset_ignored", {31'b0, busy}, 0);
    repeat (30) @(negedge clk);
    check("no_done_after_reset", n_done, nd);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    result_data = '0;
    repeat (3) @(negedge clk);
    check("reset_tx_start", {31'b0, tx_start}, 0);
    check("reset_tx_data", {24'b0, tx_data}, 0);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    reset = 1'b0;
    @(negedge clk);
    char_len = 10;
    run_frame(32'hDEADBEEF, 0, -1, 0);
    char_len = 0;
    run_frame(32'hA5A5A5A5, 0, -1, 0);
    run_frame(32'h00000001, 6, -1, 0);
    run_frame(32'hCAFEF00D, 0, 15, 0);
    run_frame(32'h01020304, 0, -1, 1);
    reset_mid_frame();
    run_frame(32'h0BADCAFE, 0, -1, 0);
    for (int n = 0; n < 10; n++)
      run_frame($urandom,
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 6)) : 0,
                ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 40)) : -1,
                1'($urandom_range(0, 1)));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1, "watchdog");
  end
endmodule
